// File: rtl/if_ctrl_pkg.sv
// Shared definitions for the IF fetch controller.
//   - 3-bit state encodings (visible on o_state for debug)
//   - default debug command bytes and the HALT instruction word
package if_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_STEP  = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;

    localparam int          DFLT_SIZE_REG_MEM = 32;
    localparam int          DFLT_SIZE_ADDR    = 8;
    localparam logic [31:0] DFLT_HALT_WORD    = 32'hFC00_0000;
    localparam logic [7:0]  DFLT_CMD_LOAD     = 8'h4C;
    localparam logic [7:0]  DFLT_CMD_CONT     = 8'h43;
    localparam logic [7:0]  DFLT_CMD_STEP     = 8'h53;

endpackage

// File: rtl/if_word_assembler.sv
// Assembles a stream of bytes into one WIDTH-bit word, MSB-first
// (the first byte of a word lands in the top byte).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        restart byte counting at the first byte of a word
//   shift_en     accept rx_byte this cycle
//   rx_byte      incoming byte
//   word         shift register contents (complete word once word_valid fired)
//   word_valid   high in the cycle the final byte of a word is accepted
module if_word_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [7:0]       rx_byte,
    output logic [WIDTH-1:0] word,
    output logic             word_valid
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CW-1:0] cnt;
    logic          last_byte;

    assign last_byte  = (cnt == CW'(NBYTES - 1));
    assign word_valid = shift_en && last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (shift_en)
                cnt <= last_byte ? '0 : cnt + CW'(1);
            // Older bytes fall off the top, so a full word needs no explicit clear.
            if (shift_en)
                word <= (word << 8) | WIDTH'(rx_byte);
        end
    end

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage sequencer driven by the debug UART.
// Loads program memory from UART bytes ('L'), then runs continuously ('C')
// or single-steps ('S'), stopping when the fetched instruction is HALT_WORD.
// Ports:
//   i_clk, i_reset              clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid       byte and 1-cycle strobe from the UART receiver
//   i_stall                     hazard-unit stall request
//   i_instruction               instruction currently fetched by IF
//   o_instruction_write         assembled word for program memory
//   o_write_addr                word address of o_instruction_write
//   o_flag_instruction_write    1-cycle program-memory write strobe
//   o_enable                    PC/IF enable
//   o_halted                    execution stopped on HALT_WORD
//   o_state                     current state encoding
//
// state | meaning
// IDLE  | after reset, waiting for the load command
// LOAD  | collecting bytes of the next program word
// WRITE | one-cycle write strobe of the assembled word
// READY | program loaded, waiting for run/step/load command
// RUN   | free running, enable follows ~stall
// STEP  | issue exactly one enable cycle, then back to READY
// HALT  | HALT word fetched, execution stopped
module if_fetch_controller
    import if_ctrl_pkg::*;
#(
    parameter int                      SIZE_REG_MEM = DFLT_SIZE_REG_MEM,
    parameter int                      SIZE_ADDR    = DFLT_SIZE_ADDR,
    parameter logic [SIZE_REG_MEM-1:0] HALT_WORD    = SIZE_REG_MEM'(DFLT_HALT_WORD),
    parameter logic [7:0]              CMD_LOAD     = DFLT_CMD_LOAD,
    parameter logic [7:0]              CMD_CONT     = DFLT_CMD_CONT,
    parameter logic [7:0]              CMD_STEP     = DFLT_CMD_STEP
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_stall,
    input  logic [SIZE_REG_MEM-1:0] i_instruction,
    output logic [SIZE_REG_MEM-1:0] o_instruction_write,
    output logic [SIZE_ADDR-1:0]    o_write_addr,
    output logic                    o_flag_instruction_write,
    output logic                    o_enable,
    output logic                    o_halted,
    output logic [2:0]              o_state
);

    localparam logic [SIZE_ADDR-1:0] ADDR_LAST = {SIZE_ADDR{1'b1}};

    logic [2:0]              state_q;
    logic [2:0]              state_d;
    logic [SIZE_ADDR-1:0]    addr_q;
    logic [SIZE_REG_MEM-1:0] word;
    logic                    word_valid;
    logic                    load_cmd;
    logic                    start_load;
    logic                    shift_en;
    logic                    halt_fetched;

    assign load_cmd     = i_rx_valid && (i_rx_data == CMD_LOAD);
    assign start_load   = load_cmd &&
                          (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_HALT);
    // Bytes arriving in WRITE are dropped: only LOAD feeds the assembler.
    assign shift_en     = i_rx_valid && (state_q == ST_LOAD);
    assign halt_fetched = (i_instruction == HALT_WORD);

    if_word_assembler #(
        .WIDTH (SIZE_REG_MEM)
    ) u_word_assembler (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (start_load),
        .shift_en   (shift_en),
        .rx_byte    (i_rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_cmd) state_d = ST_LOAD;
            ST_LOAD:  if (word_valid) state_d = ST_WRITE;
            ST_WRITE: begin
                if (word == HALT_WORD || addr_q == ADDR_LAST)
                    state_d = ST_READY;
                else
                    state_d = ST_LOAD;
            end
            ST_READY: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_CONT)
                        state_d = ST_RUN;
                    else if (i_rx_data == CMD_STEP)
                        state_d = ST_STEP;
                    else if (i_rx_data == CMD_LOAD)
                        state_d = ST_LOAD;
                end
            end
            ST_RUN:   if (halt_fetched) state_d = ST_HALT;
            ST_STEP: begin
                if (halt_fetched)
                    state_d = ST_HALT;
                else if (!i_stall)
                    state_d = ST_READY;
            end
            ST_HALT:  if (load_cmd) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_load)
                addr_q <= '0;
            else if (state_q == ST_WRITE && state_d == ST_LOAD)
                addr_q <= addr_q + SIZE_ADDR'(1);
        end
    end

    assign o_instruction_write      = word;
    assign o_write_addr             = addr_q;
    assign o_flag_instruction_write = (state_q == ST_WRITE);
    // Enable drops in the very cycle HALT is fetched so the PC never moves past it.
    // WRITE is excluded from both enabling states, so write and enable never overlap.
    assign o_enable = (state_q == ST_RUN || state_q == ST_STEP) && !i_stall && !halt_fetched;
    assign o_halted = (state_q == ST_HALT);
    assign o_state  = state_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
module tb_if_fetch_controller;
    import if_ctrl_pkg::*;

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [7:0]  C_L  = 8'h4C;
    localparam logic [7:0]  C_C  = 8'h43;
    localparam logic [7:0]  C_S  = 8'h53;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0, rx_data2 = '0;
    logic        rx_valid = 1'b0, rx_valid2 = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr = '0;

    logic [31:0] wdata, wdata2;
    logic [7:0]  waddr;
    logic [1:0]  waddr2;
    logic        wflag, wflag2, en, en2, halted, halted2;
    logic [2:0]  st, st2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_controller dut (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_stall(stall), .i_instruction(instr),
        .o_instruction_write(wdata), .o_write_addr(waddr),
        .o_flag_instruction_write(wflag), .o_enable(en), .o_halted(halted), .o_state(st)
    );

    if_fetch_controller #(.SIZE_ADDR(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data2), .i_rx_valid(rx_valid2),
        .i_stall(stall), .i_instruction(instr),
        .o_instruction_write(wdata2), .o_write_addr(waddr2),
        .o_flag_instruction_write(wflag2), .o_enable(en2), .o_halted(halted2), .o_state(st2)
    );

    // Monitor: records observed writes and enable cycles; the tests judge them.
    logic [31:0] got_word[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_word2[$];
    logic [1:0]  got_addr2[$];
    int en_cnt = 0;
    int excl_bad = 0;

    always @(negedge clk) begin
        if (wflag === 1'b1) begin
            got_word.push_back(wdata);
            got_addr.push_back(waddr);
            if (en !== 1'b0) excl_bad++;
        end
        if (wflag2 === 1'b1) begin
            got_word2.push_back(wdata2);
            got_addr2.push_back(waddr2);
        end
        if (en === 1'b1) en_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        if (sel) begin rx_data2 = b; rx_valid2 = 1'b1; end
        else     begin rx_data  = b; rx_valid  = 1'b1; end
        tick();
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic send_paced(input bit sel, input logic [7:0] b);
        send_byte(sel, b);
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_valid2 = 1'b0; stall = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        bit ok;
        do begin
            w  = $urandom;
            ok = (w != HALT);
            for (int k = 0; k < 4; k++)
                if (w[8*k +: 8] == C_L || w[8*k +: 8] == C_C || w[8*k +: 8] == C_S) ok = 0;
        end while (!ok);
        return w;
    endfunction

    // Reference: words go to consecutive addresses from 0; loading ends after the
    // HALT word or after the last address of the memory.
    task automatic load_and_check(input bit sel, input logic [31:0] prog[$], input string tag);
        int depth = sel ? 4 : 256;
        int n0 = sel ? got_word2.size() : got_word.size();
        int es0 = en_cnt;
        int ex0 = excl_bad;
        int ngot;
        bit ended = 0;
        logic [31:0] exp_w[$];
        logic [2:0]  exp_st;
        logic [2:0]  act_st;
        send_paced(sel, C_L);
        foreach (prog[i])
            for (int k = 0; k < 4; k++) send_paced(sel, prog[i][31-8*k -: 8]);
        repeat (4) tick();
        for (int i = 0; i < prog.size(); i++) begin
            exp_w.push_back(prog[i]);
            if (prog[i] == HALT || i == depth - 1) begin ended = 1; break; end
        end
        ngot = (sel ? got_word2.size() : got_word.size()) - n0;
        n_checks++;
        if (ngot != exp_w.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, ngot, exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                logic [31:0] gw = sel ? got_word2[n0+i] : got_word[n0+i];
                int          ga = sel ? int'(got_addr2[n0+i]) : int'(got_addr[n0+i]);
                n_checks++;
                if (gw !== exp_w[i] || ga != i) begin
                    n_fail++;
                    $display("FAIL %s write_%0d: got addr %0d word %h expected addr %0d word %h",
                             tag, i, ga, gw, i, exp_w[i]);
                end
            end
        end
        exp_st = ended ? ST_READY : ST_LOAD;
        act_st = sel ? st2 : st;
        n_checks++;
        if (act_st !== exp_st) begin
            n_fail++;
            $display("FAIL %s state_after_load: got %0d expected %0d", tag, act_st, exp_st);
        end
        if (!sel) begin
            n_checks++;
            if (en_cnt != es0 || excl_bad != ex0) begin
                n_fail++;
                $display("FAIL %s enable_during_load: got %0d enable cycles, %0d overlaps expected 0",
                         tag, en_cnt - es0, excl_bad - ex0);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] q[$];
        int n0;
        do_reset();
        n_checks++;
        if ({st, wflag, en, halted} !== 6'b0 || wdata !== 32'h0 || waddr !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d wf=%b en=%b h=%b w=%h a=%h expected all 0",
                     st, wflag, en, halted, wdata, waddr);
        end
        send_paced(0, C_L); send_paced(0, 8'h12); send_paced(0, 8'h34);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({st, wflag, en, halted} !== 6'b0 || wdata !== 32'h0 || waddr !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_mid_load: got st=%0d wf=%b en=%b h=%b w=%h a=%h expected all 0",
                     st, wflag, en, halted, wdata, waddr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        n0 = got_word.size();
        send_paced(0, C_L); send_paced(0, 8'h12); send_paced(0, 8'h34); send_paced(0, 8'h56);
        send_byte(0, 8'h78);
        @(negedge clk);
        n_checks++;
        if (wflag !== 1'b1 || wdata !== 32'h12345678 || waddr !== 8'h00) begin
            n_fail++;
            $display("FAIL first_word_latency: got wf=%b w=%h a=%h expected 1 12345678 00",
                     wflag, wdata, waddr);
        end
        repeat (4) tick();
        n_checks++;
        if (got_word.size() - n0 != 1 || st !== ST_LOAD) begin
            n_fail++;
            $display("FAIL first_word_count: got %0d writes state %0d expected 1 writes state %0d",
                     got_word.size() - n0, st, ST_LOAD);
        end
    endtask

    task automatic test_load_program();
        logic [31:0] p[$];
        do_reset();
        p = '{32'h20010005, 32'h20020003, HALT};
        load_and_check(0, p, "program3");
        do_reset();
        p = '{};
        repeat ($urandom_range(1, 6)) p.push_back(rand_word());
        p.push_back(HALT);
        p.push_back(rand_word());
        load_and_check(0, p, "program_rand");
    endtask

    task automatic test_run_stall();
        logic [31:0] p[$];
        do_reset();
        p = '{rand_word(), HALT};
        load_and_check(0, p, "run_prog");
        instr = rand_word();
        send_byte(0, C_C);
        n_checks++;
        if (st !== ST_RUN) begin
            n_fail++;
            $display("FAIL run_entry: got state %0d expected %0d", st, ST_RUN);
        end
        for (int i = 0; i < 40; i++) begin
            stall = (i == 10 || i == 11) ? 1'b1 : (i > 15 ? ($urandom_range(0, 3) == 0) : 1'b0);
            @(negedge clk);
            n_checks++;
            if (en !== ~stall) begin
                n_fail++;
                $display("FAIL run_enable cycle %0d: got %b expected %b", i, en, ~stall);
            end
            tick();
        end
        stall = 1'b0;
        instr = HALT;
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_same_cycle: got enable %b expected 0", en);
        end
        tick();
        instr = rand_word();
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b1 || en !== 1'b0 || st !== ST_HALT) begin
            n_fail++;
            $display("FAIL halt_next_cycle: got h=%b en=%b st=%0d expected 1 0 %0d",
                     halted, en, st, ST_HALT);
        end
        tick();
        send_paced(0, C_C);
        repeat (2) tick();
        n_checks++;
        if (halted !== 1'b1 || en !== 1'b0 || st !== ST_HALT) begin
            n_fail++;
            $display("FAIL cont_in_halt: got h=%b en=%b st=%0d expected 1 0 %0d",
                     halted, en, st, ST_HALT);
        end
    endtask

    // Random stall/instruction traffic against a two-mode (running/halted) model.
    task automatic test_random_run();
        logic [31:0] p[$];
        bit running = 1;
        bit exp_en;
        do_reset();
        p = '{rand_word(), rand_word(), HALT};
        load_and_check(0, p, "rand_run_prog");
        instr = rand_word();
        send_byte(0, C_C);
        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            instr = ($urandom_range(0, 9) == 0) ? HALT : rand_word();
            exp_en = running && !stall && (instr != HALT);
            @(negedge clk);
            n_checks++;
            if (en !== exp_en || halted !== !running) begin
                n_fail++;
                $display("FAIL random_run cycle %0d: got en=%b h=%b expected en=%b h=%b",
                         i, en, halted, exp_en, !running);
            end
            if (running && instr == HALT) running = 0;
            tick();
        end
        stall = 1'b0;
    endtask

    task automatic test_step();
        logic [31:0] p[$];
        int es0;
        do_reset();
        p = '{HALT};
        load_and_check(0, p, "step_prog");
        instr = rand_word();
        es0 = en_cnt;
        for (int i = 0; i < 3; i++) send_paced(0, C_S);
        repeat (3) tick();
        n_checks++;
        if (en_cnt - es0 != 3 || st !== ST_READY) begin
            n_fail++;
            $display("FAIL step_three: got %0d enable cycles state %0d expected 3 state %0d",
                     en_cnt - es0, st, ST_READY);
        end
        stall = 1'b1;
        send_byte(0, C_S);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (en !== 1'b0 || st !== ST_STEP) begin
                n_fail++;
                $display("FAIL step_stalled cycle %0d: got en=%b st=%0d expected 0 %0d",
                         i, en, st, ST_STEP);
            end
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL step_release: got enable %b expected 1", en);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0 || st !== ST_READY) begin
            n_fail++;
            $display("FAIL step_done: got en=%b st=%0d expected 0 %0d", en, st, ST_READY);
        end
        tick();
        instr = HALT;
        send_byte(0, C_S);
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL step_on_halt: got enable %b expected 0", en);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL step_halted: got halted %b expected 1", halted);
        end
        tick();
        instr = rand_word();
    endtask

    task automatic test_addr_limit();
        logic [31:0] p[$];
        do_reset();
        repeat (5) p.push_back(rand_word());
        load_and_check(1, p, "addr_limit");
    endtask

    initial begin
        test_reset();
        test_load_program();
        test_run_stall();
        test_random_run();
        test_step();
        test_addr_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
